// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Monitors the 4-bit counter outputs and checks that each enabled sample
//   is the previous accepted sample plus one (mod 16). It locks after
//   LOCK_LEN consecutive correct steps, flags and counts sequence faults
//   while locked, and counts 15->0 wraps seen while locked.
//
// Ports
//   clk          rising-edge clock, shared with the counter
//   rst_n        synchronous reset, active-low (wins over en and clr)
//   en           sample enable; low holds all state and outputs (err reads 0)
//   clr          clears err_sticky, err_count and wrap_count (independent of en)
//   q0..q3       counter bits, sample s = {q3,q2,q1,q0}
//   cur_count    last sampled value
//   locked       high while tracking a valid sequence
//   err          one-cycle pulse after a mismatching sample while locked
//   err_sticky   set on any mismatch, held until clr or reset
//   err_count    saturating mismatch count
//   wrap_count   saturating count of 15->0 steps seen while locked
//
// State table
//   IDLE  | no reference yet; next enabled sample becomes the base
//   SYNC  | counting consecutive correct steps towards lock
//   TRACK | locked; mismatches are reported as errors
//   FAULT | error seen; waiting for one correct step to resume syncing

module count_seq_checker #(
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              q0,
    input  logic              q1,
    input  logic              q2,
    input  logic              q3,
    output logic [3:0]        cur_count,
    output logic              locked,
    output logic              err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_LEN_4 = 4'(LOCK_LEN);

    state_t            state, state_nxt;
    logic [3:0]        base, base_nxt;
    logic [3:0]        run, run_nxt;
    logic [3:0]        s;
    logic [3:0]        nxt;
    logic              match;
    logic              mis_ev;
    logic              wrap_ev;
    logic [3:0]        cur_count_nxt;
    logic              err_sticky_nxt;
    logic [ERR_W-1:0]  err_count_nxt;
    logic [ERR_W-1:0]  err_cnt_keep;
    logic [WRAP_W-1:0] wrap_count_nxt;
    logic [WRAP_W-1:0] wrap_cnt_keep;

    assign s     = {q3, q2, q1, q0};
    assign nxt   = base + 4'd1;
    assign match = (s == nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= 4'd0;
            run        <= 4'd0;
            cur_count  <= 4'd0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            base       <= base_nxt;
            run        <= run_nxt;
            cur_count  <= cur_count_nxt;
            err        <= mis_ev;
            err_sticky <= err_sticky_nxt;
            err_count  <= err_count_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        run_nxt       = run;
        cur_count_nxt = cur_count;
        mis_ev        = 1'b0;
        wrap_ev       = 1'b0;
        if (en) begin
            base_nxt      = s;
            cur_count_nxt = s;
            case (state)
                IDLE: begin
                    run_nxt   = 4'd0;
                    state_nxt = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        run_nxt = run + 4'd1;
                        if (run + 4'd1 == LOCK_LEN_4) begin
                            state_nxt = TRACK;
                        end
                    end else begin
                        run_nxt = 4'd0;
                    end
                end
                TRACK: begin
                    if (match) begin
                        wrap_ev = (base == 4'd15);
                    end else begin
                        mis_ev    = 1'b1;
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    if (match) begin
                        // the recovering step already counts towards lock
                        run_nxt   = 4'd1;
                        state_nxt = (LOCK_LEN == 1) ? TRACK : SYNC;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // clr zeroes the counters first; an event in the same cycle then counts on top
    always_comb begin
        err_cnt_keep   = clr ? '0 : err_count;
        wrap_cnt_keep  = clr ? '0 : wrap_count;
        err_sticky_nxt = mis_ev | (err_sticky & ~clr);
        err_count_nxt  = err_cnt_keep;
        wrap_count_nxt = wrap_cnt_keep;
        if (mis_ev && (err_cnt_keep != {ERR_W{1'b1}})) begin
            err_count_nxt = err_cnt_keep + 1'b1;
        end
        if (wrap_ev && (wrap_cnt_keep != {WRAP_W{1'b1}})) begin
            wrap_count_nxt = wrap_cnt_keep + 1'b1;
        end
    end

    assign locked = (state == TRACK);

endmodule
